// File: rtl/serializador_if.sv
// Handshake bundle between the upstream word queue, the serializer and the bit sink.
interface serializador_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
);
  logic [DATA_W-1:0] data_in;
  logic [LEN_W-1:0]  len_in;
  logic              ready_in;
  logic              dequeue_out;
  logic              data_out;
  logic              valid_out;
  logic              last_out;
  logic              status_out;

  modport master (
    input  data_in, len_in, ready_in,
    output dequeue_out, data_out, valid_out, last_out, status_out
  );

  modport slave (
    output data_in, len_in, ready_in,
    input  dequeue_out, data_out, valid_out, last_out, status_out
  );
endinterface

// File: rtl/serializador.sv
// Word-to-bit serializer: fetches one word from a queue, shifts it out MSB first,
// optionally followed by an even-parity bit.
//
// state | meaning
// IDLE  | waiting for len_in != 0
// FETCH | dequeue_out high, queue read latency
// LOAD  | capture data_in and parity, clear bit counter
// SHIFT | present bits, advance on ready_in
module serializador #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4,
  parameter int PARITY = 0
) (
  input  logic           clock,
  input  logic           reset,
  serializador_if.master bus
);
  localparam int FRAME_W = DATA_W + ((PARITY != 0) ? 1 : 0);
  localparam int CNT_W   = 4;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [DATA_W:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dequeue_q, dequeue_d;
  logic              par_bit;
  logic              in_shift;

  // The parity slot always exists; with PARITY=0 it is loaded 0 and never reaches the MSB.
  assign par_bit = (PARITY != 0) ? ^bus.data_in : 1'b0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      dequeue_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      dequeue_q <= dequeue_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    dequeue_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.len_in != '0) begin
          dequeue_d = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        shreg_d = {bus.data_in, par_bit};
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (bus.ready_in) begin
          shreg_d = {shreg_q[DATA_W-1:0], 1'b0};
          if (cnt_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_shift        = (state_q == SHIFT);
  assign bus.dequeue_out = dequeue_q;
  assign bus.valid_out   = in_shift;
  assign bus.data_out    = in_shift & shreg_q[DATA_W];
  assign bus.last_out    = in_shift && (cnt_q == LAST_IDX);
  assign bus.status_out  = (state_q != IDLE);
endmodule
